// File: rtl/mdu_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
// Handshake: start is honoured only when the unit is idle (busy=0) and flush=0; done pulses one cycle with hi/lo valid.
interface mdu_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit with a fixed 34-cycle latency.
// One shared 33-bit adder serves shift-add multiply and restoring divide.
module mdu_iterative #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    mdu_if.slave       bus,
    output logic [1:0] o_dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
    localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

    state_t            r_state;
    logic [4:0]        r_cnt;
    logic              r_is_div;
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_mpl;
    logic [XLEN-1:0]   r_opb;
    logic              r_sa;
    logic              r_sb;
    logic              r_dz;
    logic              r_busy;
    logic              r_done;
    logic              r_dbz;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;

    logic              w_start_div;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN-1:0]   w_add_x;
    logic [XLEN-1:0]   w_add_y;
    logic [XLEN:0]     w_sum;
    logic              w_mul_c;
    logic [XLEN-1:0]   w_mul_acc;
    logic              w_no_borrow;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;

    // Operand capture: op[0]=0 means signed, so take two's-complement magnitudes.
    assign w_start_div = bus.op[1];
    assign w_a_neg     = ~bus.op[0] & bus.a[XLEN-1];
    assign w_b_neg     = ~bus.op[0] & bus.b[XLEN-1];
    assign w_a_mag     = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag     = w_b_neg ? -bus.b : bus.b;

    // Divide feeds the left-shifted remainder and ~divisor with cin=1; multiply adds mcand to acc.
    assign w_add_x = r_is_div ? {r_acc[XLEN-2:0], r_mpl[XLEN-1]} : r_acc;
    assign w_add_y = r_is_div ? ~r_opb : r_opb;
    assign w_sum   = {1'b0, w_add_x} + {1'b0, w_add_y} + (XLEN+1)'(r_is_div);

    assign w_mul_c   = r_mpl[0] & w_sum[XLEN];
    assign w_mul_acc = r_mpl[0] ? w_sum[XLEN-1:0] : r_acc;
    // The bit shifted out of rem[31] makes the trial value exceed any divisor.
    assign w_no_borrow = w_sum[XLEN] | r_acc[XLEN-1];

    assign w_prod     = {r_acc, r_mpl};
    assign w_prod_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;
    assign w_quo_fix  = (r_sa ^ r_sb) ? -r_mpl : r_mpl;
    assign w_rem_fix  = r_sa ? -r_acc : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_acc    <= '0;
            r_mpl    <= '0;
            r_opb    <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_dz     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_dbz  <= 1'b0;
                    if (bus.start) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_is_div <= w_start_div;
                        r_sa     <= w_a_neg;
                        r_sb     <= w_b_neg;
                        r_dz     <= w_start_div && (bus.b == '0);
                        r_acc    <= '0;
                        r_mpl    <= w_start_div ? w_a_mag : w_b_mag;
                        r_opb    <= w_start_div ? w_b_mag : w_a_mag;
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        r_acc <= w_no_borrow ? w_sum[XLEN-1:0] : w_add_x;
                        r_mpl <= {r_mpl[XLEN-2:0], w_no_borrow};
                    end else begin
                        r_acc <= {w_mul_c, w_mul_acc[XLEN-1:1]};
                        r_mpl <= {w_mul_acc[0], r_mpl[XLEN-1:1]};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == LAST_CNT) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        // Zero divisor leaves rem=|a|; re-signing restores the original dividend.
                        r_hi <= w_rem_fix;
                        r_lo <= r_dz ? '1 : w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*XLEN-1:XLEN];
                        r_lo <= w_prod_fix[XLEN-1:0];
                    end
                    r_done  <= 1'b1;
                    r_dbz   <= r_dz;
                    r_state <= S_DONE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_dbz   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: latency, signed/unsigned results, divide by zero,
// ignored start, flush and asynchronous reset.
module tb_mdu_iterative;
    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         n_total;
    int         n_bad;
    int         lat;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mdu_if u_if ();

    mdu_iterative u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (u_if.slave),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Issues one op; pulse_at re-asserts start mid-op, flush_at flushes in that cycle (0 = unused).
    // lat returns the cycle in which done was first seen, or 0 if never within the budget.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int pulse_at, input int flush_at, output int lat_o);
        logic [31:0] prev_lo;
        lat_o   = 0;
        prev_lo = u_if.lo;
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.op    = op;
        u_if.a     = a;
        u_if.b     = b;
        u_if.flush = 1'b0;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        check("busy_c1", 32'(u_if.busy), 32'd1);
        for (int k = 1; k <= 40; k++) begin
            if (flush_at > 0 && k == flush_at + 1) check("busy_after_flush", 32'(u_if.busy), 32'd0);
            if (k == 33) check("lo_hold_fix", u_if.lo, prev_lo);
            if (lat_o != 0 && k == lat_o + 1) begin
                check("busy_c35", 32'(u_if.busy), 32'd0);
                check("done_c35", 32'(u_if.done), 32'd0);
                break;
            end
            if (u_if.done && lat_o == 0) lat_o = k;
            u_if.start = (k == pulse_at);
            if (k == pulse_at) begin
                u_if.op = OP_MULTU;
                u_if.a  = 32'd5;
                u_if.b  = 32'd9;
            end
            u_if.flush = (k == flush_at);
            @(posedge clk);
            #1;
        end
        u_if.start = 1'b0;
        u_if.flush = 1'b0;
    endtask

    task automatic check_result(input string tag, input int lat_v, input logic [31:0] hi_e,
                                input logic [31:0] lo_e, input logic dz_e);
        check({tag, "_lat"}, 32'(lat_v), 32'd34);
        check({tag, "_hi"}, u_if.hi, hi_e);
        check({tag, "_lo"}, u_if.lo, lo_e);
        check({tag, "_dz"}, 32'(u_if.div_by_zero), 32'(dz_e));
    endtask

    // div_by_zero is only meaningful with done, so latch it when done is seen.
    logic dz_seen;
    always @(posedge clk) begin
        #1;
        if (u_if.done) dz_seen = u_if.div_by_zero;
    end

    initial begin
        n_total    = 0;
        n_bad      = 0;
        dz_seen    = 1'b0;
        rst_n      = 1'b0;
        u_if.start = 1'b0;
        u_if.op    = 2'b00;
        u_if.a     = '0;
        u_if.b     = '0;
        u_if.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(u_if.busy), 32'd0);
        check("rst_done", 32'(u_if.done), 32'd0);
        check("rst_dz", 32'(u_if.div_by_zero), 32'd0);
        check("rst_hi", u_if.hi, 32'h0);
        check("rst_lo", u_if.lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, lat);
        check_result("multu_max", lat, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        check("multu_max_dzd", 32'(dz_seen), 32'd0);

        run_op(OP_MULT, 32'hFFFFFFFD, 32'h00000005, 0, 0, lat);
        check_result("mult_neg", lat, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_op(OP_MULT, 32'd7, 32'd6, 0, 0, lat);
        check_result("mult_pos", lat, 32'h0, 32'h0000002A, 1'b0);

        run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 0, 0, lat);
        check_result("div_neg", lat, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op(OP_DIVU, 32'd100, 32'd7, 0, 0, lat);
        check_result("divu", lat, 32'h00000002, 32'h0000000E, 1'b0);

        dz_seen = 1'b0;
        run_op(OP_DIVU, 32'h00001234, 32'h0, 0, 0, lat);
        check_result("divu_zero", lat, 32'h00001234, 32'hFFFFFFFF, 1'b0);
        check("divu_zero_dzd", 32'(dz_seen), 32'd1);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'h0, 0, 0, lat);
        check_result("div_zero_neg", lat, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
        dz_seen = 1'b0;
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, lat);
        check_result("div_ovf", lat, 32'h0, 32'h80000000, 1'b0);
        check("div_ovf_dzd", 32'(dz_seen), 32'd0);

        run_op(OP_MULTU, 32'd3, 32'd4, 10, 0, lat);
        check_result("start_ignored", lat, 32'h0, 32'h0000000C, 1'b0);
        run_op(OP_MULTU, 32'd9, 32'd9, 0, 20, lat);
        check("flush_no_done", 32'(lat), 32'd0);
        check("flush_hi", u_if.hi, 32'h0);
        check("flush_lo", u_if.lo, 32'h0000000C);

        // start and flush together in IDLE: flush wins.
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.flush = 1'b1;
        u_if.op    = OP_MULTU;
        u_if.a     = 32'd2;
        u_if.b     = 32'd3;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        u_if.flush = 1'b0;
        check("flush_prio_busy", 32'(u_if.busy), 32'd0);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.op    = OP_MULTU;
        u_if.a     = 32'd9;
        u_if.b     = 32'd9;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(u_if.busy), 32'd0);
        check("arst_done", 32'(u_if.done), 32'd0);
        check("arst_hi", u_if.hi, 32'h0);
        check("arst_lo", u_if.lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_MULTU, 32'd2, 32'd2, 0, 0, lat);
        check_result("post_rst", lat, 32'h0, 32'h00000004, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Iterative multiply/divide unit in the EX stage, alongside the 32-bit ALU adder.
- Executes MULT, MULTU, DIV and DIVU over a fixed 34-cycle latency.
- Produces HI/LO results for the mfhi/mflo path.
- Datapath uses one shared 32-bit adder/subtractor with carry-out, reused every iteration. No array multiplier.

Parameters:
- XLEN, 32, operand width. Only 32 is supported.
- ITER, 32, iteration cycles. Must equal XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  operation request; sampled only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  input  32  multiplicand / dividend
- b  input  32  multiplier / divisor
- flush  input  1  pipeline flush; aborts any in-flight operation
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse; hi/lo are valid in this cycle
- div_by_zero  output  1  high with done when a divide had b==0
- hi  output  32  product[63:32] / remainder
- lo  output  32  product[31:0] / quotient

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy, done, div_by_zero = 0.
  - hi, lo = 32'h0.
  - Iteration counter and working registers = 0.
- States: IDLE -> RUN -> FIX -> DONE -> IDLE.
- IDLE: on start=1 (and flush=0), latch op, the magnitude of each operand, and the operand signs; counter=0; go to RUN.
  - Magnitude is the two's-complement absolute value for signed ops and the raw value for unsigned ops.
- RUN lasts exactly 32 cycles; counter runs 0..31; go to FIX when counter==31.
  - Multiply: shift-add on 64-bit {acc, mplier}. If mplier[0], acc+mcand with 33-bit carry. Then shift the 65-bit {carry, acc, mplier} right by 1.
  - Divide: restoring. {rem, quo} shifts left 1. Trial = rem - divisor, computed as rem + ~divisor with cin=1. If no borrow (carry-out=1): rem=trial, quo[0]=1. Otherwise restore and quo[0]=0.
- FIX (1 cycle): apply signs, then write hi/lo.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Unsigned ops: no correction.
  - hi/lo are written at the end of FIX.
- DONE (1 cycle): done=1; div_by_zero set if a divide op had b==0; return to IDLE.
- Timing, with start sampled in cycle 0:
  - busy=1 in cycles 1..34.
  - done=1 in cycle 34 only.
  - Next start is accepted in cycle 35.
- start while busy: ignored, with no queuing and no effect on the in-flight op.
- hi/lo hold their last completed result until the next FIX. They are never changed mid-operation.
- Divide by zero: fixed latency is kept.
  - hi = a (the original dividend, as given).
  - lo = 32'hFFFFFFFF.
  - div_by_zero=1 during done.
- DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0. No trap; wraps naturally.
- flush=1 in any state: next state is IDLE; busy=0 next cycle; no done; hi/lo unchanged.
  - flush has priority over start in the same cycle.
- flush asserted during DONE: done is still high that cycle, since the result was already committed in FIX.
- Reset mid-operation: immediate return to the reset values above; the partial result is discarded.

Test Plan:
- MULTU a=FFFFFFFF b=FFFFFFFF -> done in cycle 34, hi=FFFFFFFE, lo=00000001, div_by_zero=0.
- MULT a=FFFFFFFD(-3) b=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1 (-15); then MULT 7*6 -> hi=0, lo=0000002A.
- DIV a=FFFFFFF9(-7) b=00000002 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1); DIVU a=00000064 b=00000007 -> lo=0000000E, hi=00000002.
- DIVU a=00001234 b=0 -> done in cycle 34 with div_by_zero=1, hi=00001234, lo=FFFFFFFF; DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
- Start MULTU 3*4, pulse start with different operands in cycle 10 -> ignored, result hi=0 lo=0000000C; flush in cycle 20 of a second op -> busy=0 in cycle 21, no done, hi/lo still 0/0000000C.
- Assert rst_n=0 asynchronously mid-RUN -> busy, done, hi, lo = 0 immediately; release, then a new MULTU 2*2 -> lo=00000004 at cycle 34.
